// File: rtl/serial_mag_compare.sv
// Bit-serial unsigned magnitude comparator, MSB-first with early exit on the first
// differing bit; start/busy/done handshake, flags x (a>b), y (a==b), z (a<b).
//
//   state | meaning
//   IDLE  | waiting for start, last result held on x/y/z
//   SHIFT | comparing one bit pair per clock
//   DONE  | one-cycle result strobe; start here begins the next compare at once
module serial_mag_compare #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             x,
  output logic             y,
  output logic             z
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sa_nxt;
  logic [WIDTH-1:0] sb, sb_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             x_nxt, y_nxt, z_nxt;
  logic             busy_nxt, done_nxt;
  logic             sa_msb, sb_msb;

  assign sa_msb = sa[WIDTH-1];
  assign sb_msb = sb[WIDTH-1];

  always_comb begin
    state_nxt = state;
    sa_nxt    = sa;
    sb_nxt    = sb;
    cnt_nxt   = cnt;
    x_nxt     = x;
    y_nxt     = y;
    z_nxt     = z;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          sa_nxt    = a;
          sb_nxt    = b;
          cnt_nxt   = CW'(WIDTH - 1);
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (sa_msb != sb_msb) begin
          x_nxt     = sa_msb & ~sb_msb;
          y_nxt     = 1'b0;
          z_nxt     = ~sa_msb & sb_msb;
          state_nxt = DONE;
        end else if (cnt == '0) begin
          x_nxt     = 1'b0;
          y_nxt     = 1'b1;
          z_nxt     = 1'b0;
          state_nxt = DONE;
        end else begin
          sa_nxt  = {sa[WIDTH-2:0], 1'b0};
          sb_nxt  = {sb[WIDTH-2:0], 1'b0};
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // busy/done are flopped from the next state so they leave the block registered
    busy_nxt = (state_nxt == SHIFT);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      x     <= 1'b0;
      y     <= 1'b0;
      z     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      sa    <= sa_nxt;
      sb    <= sb_nxt;
      cnt   <= cnt_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      z     <= z_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_serial_mag_compare.sv
// Directed-vector bench for serial_mag_compare (WIDTH=4) with hand-computed
// latencies and flags; all checks go through chk().
module tb_serial_mag_compare;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic       x;
  logic       y;
  logic       z;

  int vec_cnt;
  int err_cnt;

  serial_mag_compare #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .x    (x),
    .y    (y),
    .z    (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // tick until done is seen; n = edges after the accept edge, bounded
  task automatic wait_done(input string tag, output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      tick();
      n++;
    end
    if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  // accept a/b, expect done after exp_k edges with flags exp_xyz
  task automatic do_compare(input string tag, input logic [3:0] av, input logic [3:0] bv,
                            input int exp_k, input logic [2:0] exp_xyz);
    int n, bn;
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av;
    b = ~bv;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    wait_done(tag, n, bn);
    chk({tag, "_latency"}, 32'(n), 32'(exp_k));
    chk({tag, "_busy_cycles"}, 32'(bn), 32'(exp_k));
    chk({tag, "_xyz"}, 32'({x, y, z}), 32'(exp_xyz));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "_xyz_hold"}, 32'({x, y, z}), 32'(exp_xyz));
  endtask

  initial begin
    int n, bn, seen;
    vec_cnt = 0;
    err_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    chk("reset_outs", 32'({busy, done, x, y, z}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_outs", 32'({busy, done, x, y, z}), 32'd0);

    do_compare("gt_msb", 4'b1001, 4'b0111, 1, 3'b100);
    do_compare("lt_lsb", 4'b0110, 4'b0111, 4, 3'b001);
    do_compare("eq_1010", 4'b1010, 4'b1010, 4, 3'b010);
    do_compare("eq_zero", 4'b0000, 4'b0000, 4, 3'b010);
    do_compare("gt_lsb", 4'b1111, 4'b1110, 4, 3'b100);
    do_compare("lt_msb", 4'b0000, 4'b1000, 1, 3'b001);
    do_compare("gt_bit2", 4'b0100, 4'b0011, 2, 3'b100);

    // back-to-back: start held through the DONE cycle
    a = 4'b1001;
    b = 4'b0111;
    start = 1'b1;
    tick();
    wait_done("b2b_first", n, bn);
    chk("b2b_first_xyz", 32'({x, y, z}), 32'b100);
    a = 4'b0001;
    b = 4'b0010;
    tick();
    start = 1'b0;
    chk("b2b_no_idle_busy", 32'(busy), 32'd1);
    chk("b2b_hold_first", 32'({x, y, z}), 32'b100);
    wait_done("b2b_second", n, bn);
    chk("b2b_latency", 32'(n), 32'd3);
    chk("b2b_xyz", 32'({x, y, z}), 32'b001);
    tick();

    // start during SHIFT ignored, operands not re-sampled
    a = 4'b1111;
    b = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'b0000;
    b = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign", n, bn);
    chk("ign_latency", 32'(n + 2), 32'd4);
    chk("ign_xyz", 32'({x, y, z}), 32'b010);
    tick();
    chk("ign_no_requeue", 32'({busy, done}), 32'd0);

    // async reset mid-SHIFT; flags were y=1 before
    a = 4'b1111;
    b = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", 32'({busy, done, x, y, z}), 32'd0);
    tick();
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) seen++;
    end
    chk("rst_no_done", 32'(seen), 32'd0);
    chk("rst_flags_clear", 32'({x, y, z}), 32'd0);
    do_compare("post_rst", 4'b0101, 4'b0110, 3, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
